// File: rtl/keccak_out_piso.sv
// Parallel-in/serial-out unloader for a squeezed Keccak rate block: emits up to
// WORDS words of W bits, LSW first. Optional build macro: KECCAK_PISO_BYTESWAP_EN.
module keccak_out_piso #(
  parameter int WORDS = 42,
  parameter int W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORDS*W-1:0] block_in,
  input  logic [10:0]        block_len,
  input  logic               block_valid,
  output logic               block_ready,
  input  logic               flush,
  output logic [W-1:0]       dout,
  output logic               dst_write,
  input  logic               dst_ready,
  output logic               last_out_word,
  output logic               busy
);

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  localparam logic [10:0] WORDS_L = 11'(WORDS);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [10:0]          r_count;
  logic [10:0]          w_count_nxt;
  logic [WORDS*W-1:0]   r_shift;
  logic [WORDS*W-1:0]   w_shift_nxt;
  logic [10:0]          w_len_clamp;
  logic                 w_last;
  logic                 w_take;
  logic                 w_ready;
  logic                 w_load;

  function automatic logic [W-1:0] byte_swap(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W / 8; b++) begin
      r[8*b +: 8] = d[W-8-8*b +: 8];
    end
    return r;
  endfunction

  assign w_len_clamp = (block_len > WORDS_L) ? WORDS_L : block_len;
  assign w_last      = (r_state == ST_LOADED) && (r_count == 11'd1);
  assign w_take      = (r_state == ST_LOADED) && dst_ready;
  // Reload is allowed on the final-word handshake so blocks stream without a bubble.
  assign w_ready     = !flush && ((r_state == ST_EMPTY) || (w_last && dst_ready));
  assign w_load      = block_valid && w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_count <= 11'd0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shift_nxt = r_shift;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_count_nxt = 11'd0;
      w_shift_nxt = '0;
    end else if (w_load) begin
      // A zero-length block is consumed but leaves nothing to emit.
      w_shift_nxt = block_in;
      w_count_nxt = w_len_clamp;
      w_state_nxt = (w_len_clamp == 11'd0) ? ST_EMPTY : ST_LOADED;
    end else if (w_take) begin
      w_shift_nxt = r_shift >> W;
      if (w_last) begin
        w_state_nxt = ST_EMPTY;
        w_count_nxt = 11'd0;
      end else begin
        w_count_nxt = r_count - 11'd1;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign block_ready   = w_ready;
  assign dst_write     = (r_state == ST_LOADED);
  assign last_out_word = w_last;
  assign busy          = (r_state == ST_LOADED);

`ifdef KECCAK_PISO_BYTESWAP_EN
  assign dout = byte_swap(r_shift[W-1:0]);
`else
  assign dout = r_shift[W-1:0];
`endif

endmodule
